// File: rtl/mprj_io_cfg_loader.sv
// Purpose : per-pad configuration store plus serial sequencer that shifts every word
//           into the mprj_io pad-control chain and then strobes serial_load.
// Latency : xfer_start -> busy/first bit in 1 cycle; busy for 2*CLK_DIV*NUM_PADS*CFG_BITS + CLK_DIV cycles.
// Backpr. : no handshake; writes and xfer_start are dropped while busy, and xfer_start is also dropped in the DONE cycle.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata   store write port (pad index, word)
//   cfg_re/cfg_rdata            readback port (live only with MPRJ_IO_CFG_READBACK_EN)
//   xfer_start, busy, done      transfer request and status
//   serial_clock/serial_data_out/serial_load/serial_resetn   pad-ring chain
//
// Build option: define MPRJ_IO_CFG_READBACK_EN to enable the readback mux;
// without it cfg_re is ignored and cfg_rdata is tied to 0.

module mprj_io_cfg_loader #(
   parameter int                  NUM_PADS = 38,
   parameter int                  CFG_BITS = 13,
   parameter int                  CLK_DIV  = 2,
   parameter logic [CFG_BITS-1:0] CFG_INIT = CFG_BITS'(13'h0403)
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                cfg_we,
   input  logic [5:0]          cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_wdata,
   input  logic                cfg_re,
   output logic [CFG_BITS-1:0] cfg_rdata,
   input  logic                xfer_start,
   output logic                busy,
   output logic                done,
   output logic                serial_clock,
   output logic                serial_data_out,
   output logic                serial_load,
   output logic                serial_resetn
);

   localparam int PW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
   localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
   localparam int DW = (CLK_DIV  > 1) ? $clog2(CLK_DIV)  : 1;

   localparam logic [PW-1:0] PAD_LAST = PW'(NUM_PADS - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LOAD,
      S_DONE
   } state_t;

   // Configuration store
   logic [CFG_BITS-1:0] r_store [NUM_PADS];

   // Sequencer state
   state_t        r_state;
   logic [PW-1:0] r_pad;
   logic [BW-1:0] r_bit;
   logic [DW-1:0] r_div;

   // Registered outputs
   logic r_busy;
   logic r_done;
   logic r_sclk;
   logic r_sdo;
   logic r_load;
   logic r_resetn;

   // Next-state / datapath wires
   state_t              w_state_nxt;
   logic [PW-1:0]       w_pad_nxt;
   logic [BW-1:0]       w_bit_nxt;
   logic [DW-1:0]       w_div_nxt;
   logic                w_sdo_upd;
   logic                w_div_last;
   logic [CFG_BITS-1:0] w_word;
   logic                w_sdo_bit;
   logic [PW-1:0]       w_addr;
   logic                w_addr_ok;
   logic                w_wr_ok;

   assign w_div_last = (r_div == DIV_LAST);

   // Address is range-checked at full width; the truncated copy is only used
   // once the check has passed.
   assign w_addr    = PW'(cfg_addr);
   assign w_addr_ok = ({26'd0, cfg_addr} < 32'(NUM_PADS));
   assign w_wr_ok   = cfg_we && !r_busy && w_addr_ok;

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pad_nxt   = r_pad;
      w_bit_nxt   = r_bit;
      w_div_nxt   = r_div;
      w_sdo_upd   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (xfer_start) begin
               w_state_nxt = S_SHIFT_LO;
               w_pad_nxt   = PAD_LAST;
               w_bit_nxt   = BIT_LAST;
               w_div_nxt   = '0;
               w_sdo_upd   = 1'b1;
            end
         end

         S_SHIFT_LO: begin
            if (w_div_last) begin
               w_state_nxt = S_SHIFT_HI;
               w_div_nxt   = '0;
            end else begin
               w_div_nxt = r_div + DW'(1);
            end
         end

         S_SHIFT_HI: begin
            if (w_div_last) begin
               w_div_nxt = '0;
               if (r_bit == '0) begin
                  if (r_pad == '0) begin
                     w_state_nxt = S_LOAD;
                  end else begin
                     w_state_nxt = S_SHIFT_LO;
                     w_pad_nxt   = r_pad - PW'(1);
                     w_bit_nxt   = BIT_LAST;
                     w_sdo_upd   = 1'b1;
                  end
               end else begin
                  w_state_nxt = S_SHIFT_LO;
                  w_bit_nxt   = r_bit - BW'(1);
                  w_sdo_upd   = 1'b1;
               end
            end else begin
               w_div_nxt = r_div + DW'(1);
            end
         end

         S_LOAD: begin
            if (w_div_last) begin
               w_state_nxt = S_DONE;
               w_div_nxt   = '0;
            end else begin
               w_div_nxt = r_div + DW'(1);
            end
         end

         S_DONE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Next data bit is fetched from the store using the advanced counters, so
   // serial_data_out only moves on the HI->LO boundary (or on start).
   always_comb begin
      w_word    = r_store[w_pad_nxt];
      w_sdo_bit = w_word[w_bit_nxt];
   end

   // ---------------------------------------------------------------
   // State register and registered outputs
   // ---------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      r_resetn <= ~wb_rst_i;
      if (wb_rst_i) begin
         r_state <= S_IDLE;
         r_pad   <= '0;
         r_bit   <= '0;
         r_div   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sclk  <= 1'b0;
         r_sdo   <= 1'b0;
         r_load  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pad   <= w_pad_nxt;
         r_bit   <= w_bit_nxt;
         r_div   <= w_div_nxt;
         // Outputs are decoded from the next state so they line up with it
         // while still coming straight from flops.
         r_busy  <= (w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI) ||
                    (w_state_nxt == S_LOAD);
         r_done  <= (w_state_nxt == S_DONE);
         r_sclk  <= (w_state_nxt == S_SHIFT_HI);
         r_load  <= (w_state_nxt == S_LOAD);
         if (w_sdo_upd) begin
            r_sdo <= w_sdo_bit;
         end
      end
   end

   // ---------------------------------------------------------------
   // Configuration store
   // ---------------------------------------------------------------
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < NUM_PADS; i++) begin
            r_store[i] <= CFG_INIT;
         end
      end else if (w_wr_ok) begin
         r_store[w_addr] <= cfg_wdata;
      end
   end

`ifdef MPRJ_IO_CFG_READBACK_EN
   logic [CFG_BITS-1:0] r_rdata;

   // Reads are permitted during a transfer; the value is held between reads.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_rdata <= '0;
      end else if (cfg_re) begin
         r_rdata <= w_addr_ok ? r_store[w_addr] : '0;
      end
   end

   assign cfg_rdata = r_rdata;
`else
   logic w_unused_re;
   assign w_unused_re = cfg_re;
   assign cfg_rdata   = '0;
`endif

   assign busy            = r_busy;
   assign done            = r_done;
   assign serial_clock    = r_sclk;
   assign serial_data_out = r_sdo;
   assign serial_load     = r_load;
   assign serial_resetn   = r_resetn;

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// Purpose : bench for mprj_io_cfg_loader with a small chain (2 pads x 13 bits, divider 3).
// Latency : expected chain bits are queued at xfer_start and popped on each rising serial_clock.
// Backpr. : none; the bench paces itself on done with bounded waits.

module tb_mprj_io_cfg_loader;

   localparam int N   = 2;
   localparam int B   = 13;
   localparam int DIV = 3;
   localparam int EXP_BUSY = 2 * DIV * N * B + DIV;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [5:0]    addr;
   logic [B-1:0]  wdata;
   logic          re;
   logic [B-1:0]  rdata;
   logic          start;
   logic          busy;
   logic          done;
   logic          sclk;
   logic          sdo;
   logic          load;
   logic          resetn;

   always #5 clk = ~clk;

   mprj_io_cfg_loader #(
      .NUM_PADS (N),
      .CFG_BITS (B),
      .CLK_DIV  (DIV),
      .CFG_INIT (13'h0403)
   ) u_dut (
      .wb_clk_i        (clk),
      .wb_rst_i        (rst),
      .cfg_we          (we),
      .cfg_addr        (addr),
      .cfg_wdata       (wdata),
      .cfg_re          (re),
      .cfg_rdata       (rdata),
      .xfer_start      (start),
      .busy            (busy),
      .done            (done),
      .serial_clock    (sclk),
      .serial_data_out (sdo),
      .serial_load     (load),
      .serial_resetn   (resetn)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference store and expected chain stream
   logic [B-1:0] model [N];
   logic         exp_q [$];
   bit           abort = 1'b0;
   int           xfers = 0;

   // ---------------------------------------------------------------
   // Chain monitor (samples on the falling clock edge)
   // ---------------------------------------------------------------
   logic prev_sclk = 1'b0;
   logic prev_busy = 1'b0;
   logic prev_load = 1'b0;
   logic prev_sdo  = 1'b0;
   int   busy_len  = 0;
   int   lo_run    = 0;
   int   hi_run    = 0;
   int   load_len  = 0;
   int   done_cnt  = 0;
   int   rises     = 0;

   always @(negedge clk) begin
      logic e;
      if (done === 1'b1) done_cnt++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
         rises++;
         if (!abort) chk("lo_half", lo_run, DIV);
         lo_run = 0;
         if (exp_q.size() == 0) begin
            chk("unexpected_bit", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("chain_bit", sdo, e);
         end
      end
      if (sclk === 1'b0 && prev_sclk === 1'b1) begin
         if (!abort) chk("hi_half", hi_run, DIV);
         hi_run = 0;
      end
      if (busy === 1'b1 && prev_busy === 1'b1 && sdo !== prev_sdo)
         chk("sdo_moves_at_fall", {sclk, prev_sclk}, 2'b01);
      if (load === 1'b1 && prev_load === 1'b0)
         chk("load_after_last_bit", exp_q.size(), 0);
      if (busy === 1'b1) busy_len++;
      if (busy === 1'b1 && sclk === 1'b0) lo_run++;
      if (sclk === 1'b1) hi_run++;
      if (load === 1'b1) load_len++;
      if (busy === 1'b0 && prev_busy === 1'b1) begin
         if (!abort) begin
            chk("busy_len", busy_len, EXP_BUSY);
            chk("done_at_busy_fall", done, 1);
            chk("load_len", load_len, DIV);
            chk("stream_complete", exp_q.size(), 0);
         end else begin
            chk("no_done_on_abort", done, 0);
         end
         busy_len = 0;
         lo_run   = 0;
         hi_run   = 0;
         load_len = 0;
      end
      prev_sclk = sclk;
      prev_busy = busy;
      prev_load = load;
      prev_sdo  = sdo;
   end

   // ---------------------------------------------------------------
   // Stimulus tasks (inputs change 1 time unit after the rising edge)
   // ---------------------------------------------------------------
   task automatic cfg_write(input logic [5:0] a, input logic [B-1:0] d, input bit accept);
      @(posedge clk); #1;
      we = 1'b1; addr = a; wdata = d;
      @(posedge clk); #1;
      we = 1'b0;
      if (accept) model[int'(a)] = d;
   endtask

   task automatic cfg_read(input string tag, input logic [5:0] a, input logic [B-1:0] exp_val);
      logic [B-1:0] exp_r;
`ifdef MPRJ_IO_CFG_READBACK_EN
      exp_r = exp_val;
`else
      exp_r = '0;
`endif
      @(posedge clk); #1;
      re = 1'b1; addr = a;
      @(posedge clk); #1;
      re = 1'b0;
      @(negedge clk);
      chk(tag, rdata, exp_r);
   endtask

   task automatic start_xfer(input bit push);
      @(posedge clk); #1;
      if (push) begin
         for (int p = N - 1; p >= 0; p--)
            for (int b = B - 1; b >= 0; b--)
               exp_q.push_back(model[p][b]);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 3000) begin
         @(negedge clk);
         n++;
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) chk({tag, "_timeout"}, 0, 1);
      xfers++;
      repeat (2) @(negedge clk);
      chk({tag, "_done_count"}, done_cnt, xfers);
   endtask

   // ---------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------
   initial begin
      int r0;
      int n;
      rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; re = 1'b0; start = 1'b0;
      for (int i = 0; i < N; i++) model[i] = 13'h0403;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",   busy,   0);
      chk("rst_done",   done,   0);
      chk("rst_sclk",   sclk,   0);
      chk("rst_sdo",    sdo,    0);
      chk("rst_load",   load,   0);
      chk("rst_resetn", resetn, 0);
      chk("rst_rdata",  rdata,  0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("resetn_after_rst", resetn, 1);

      // Transfer of reset defaults
      start_xfer(1'b1);
      wait_done("defaults");

      // Order check plus dropped out-of-range writes
      cfg_write(6'd0,  13'h1ABC, 1'b1);
      cfg_write(6'd1,  13'h0155, 1'b1);
      cfg_write(6'd40, 13'h1FFF, 1'b0);
      cfg_write(6'd2,  13'h0000, 1'b0);
      start_xfer(1'b1);
      // Mid-transfer write and restart request are both ignored
      repeat (10) @(posedge clk);
      cfg_write(6'd1, 13'h1FFF, 1'b0);
      start_xfer(1'b0);
      wait_done("order");

      cfg_read("rb_pad1_old", 6'd1, 13'h0155);
      cfg_read("rb_pad0",     6'd0, 13'h1ABC);
      cfg_write(6'd1, 13'h1FFF, 1'b1);
      cfg_read("rb_pad1_new", 6'd1, 13'h1FFF);
      cfg_read("rb_oor",      6'd40, 13'h0000);

      start_xfer(1'b1);
      wait_done("after_write");

      // Reset in the middle of a transfer
      r0 = rises;
      start_xfer(1'b1);
      n = 0;
      while (rises < r0 + 7 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (rises < r0 + 7) chk("abort_wait_timeout", 0, 1);
      @(posedge clk); #1;
      abort = 1'b1;
      rst   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("abort_busy",   busy,   0);
      chk("abort_resetn", resetn, 0);
      chk("abort_sclk",   sclk,   0);
      chk("abort_load",   load,   0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) model[i] = 13'h0403;
      repeat (8) @(negedge clk);
      chk("abort_no_done", done_cnt, xfers);
      abort = 1'b0;

      for (int i = 0; i < N; i++) cfg_read("rb_after_abort", 6'(i), 13'h0403);

      start_xfer(1'b1);
      wait_done("post_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mprj_io_cfg_loader.md
# mprj_io_cfg_loader

Serial configuration sequencer for the user-project I/O pad ring. It holds one configuration word per `mprj_io` pad, written by management firmware through a simple register port. On command, it shifts the whole set out over the pad-ring serial chain (`serial_clock` / `serial_data_out`) and then pulses `serial_load` so every per-pad control block latches its new mode. It sits in housekeeping, between the management register bus and the pad-control chain that drives `mprj_io_dm`, `mprj_io_oeb`, `mprj_io_inp_dis` and the related pad controls.

## Interface
Parameters:
- `NUM_PADS`, 38: number of pads in the chain; equals `MPRJ_IO_PADS`.
- `CFG_BITS`, 13: configuration bits per pad.
- `CLK_DIV`, 2: `wb_clk_i` cycles per serial clock half-period; legal range ≥ 1.
- `CFG_INIT`, 13'h0403: reset value of every configuration word.

Ports (clock and reset first):
- `wb_clk_i`, input, 1: the block's only clock.
- `wb_rst_i`, input, 1: reset; synchronous, active-high.
- `cfg_we`, input, 1: write strobe for the configuration store.
- `cfg_addr`, input, 6: pad index.
- `cfg_wdata`, input, CFG_BITS: word to write.
- `cfg_re`, input, 1: read strobe; only meaningful with the readback macro.
- `cfg_rdata`, output, CFG_BITS: readback data.
- `xfer_start`, input, 1: one-cycle request to start a transfer.
- `busy`, output, 1: transfer in progress.
- `done`, output, 1: one-cycle pulse when a transfer completes.
- `serial_clock`, output, 1: chain shift clock.
- `serial_data_out`, output, 1: chain data.
- `serial_load`, output, 1: chain latch strobe.
- `serial_resetn`, output, 1: chain reset, active-low.

## Operation
- **Store.** `NUM_PADS` × `CFG_BITS` registers.
  - A write takes effect the cycle after `cfg_we` when `busy`=0 and `cfg_addr` < `NUM_PADS`.
  - A write with `busy`=1 or an out-of-range address is silently dropped.
- **States.** IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- **IDLE.**
  - `xfer_start`=1 → SHIFT_LO, with the pad counter at `NUM_PADS-1` and the bit counter at `CFG_BITS-1`.
  - `xfer_start` while not in IDLE is ignored.
- **SHIFT_LO.** Lasts `CLK_DIV` cycles.
  - `serial_clock`=0.
  - `serial_data_out` = cfg[pad][bit], registered and stable for the whole LO+HI period.
  - Then → SHIFT_HI.
- **SHIFT_HI.** Lasts `CLK_DIV` cycles with `serial_clock`=1.
  - At the end, the counters advance: bit decrements; when bit wraps from 0 to `CFG_BITS-1`, pad decrements.
  - After bit 0 of pad 0 → LOAD; otherwise → SHIFT_LO.
- **Bit order.** Highest pad first, MSB first. Pad 0's LSB is the last bit shifted, because the chain is a shift register fed from the far end.
- **LOAD.** Lasts `CLK_DIV` cycles with `serial_load`=1, `serial_clock`=0, then → DONE.
- **DONE.** Lasts 1 cycle with `done`=1, `busy`=0, then → IDLE.
- **`busy`.** 1 in SHIFT_LO, SHIFT_HI and LOAD.
- **Back-to-back.** An `xfer_start` that arrives in the DONE cycle is ignored. Firmware re-issues it in IDLE.
- **`serial_resetn`.** Registered `~wb_rst_i`: 0 during reset and 1 from the first cycle after reset deasserts.
- **Reset mid-transfer.**
  - The FSM goes to IDLE and the counters clear.
  - All store words return to `CFG_INIT`.
  - No `done` pulse is produced.
  - Pads see `serial_resetn`=0 and revert to their own defaults.

## Timing
- **Reset values.** `busy`=0, `done`=0, `serial_clock`=0, `serial_data_out`=0, `serial_load`=0, `serial_resetn`=0, `cfg_rdata`=0.
- **Start.** `xfer_start` sampled in cycle T puts the FSM in SHIFT_LO at T+1, with `busy`=1 and the first data bit valid.
- **Duration.** `busy` stays high for exactly 2·`CLK_DIV`·`NUM_PADS`·`CFG_BITS` + `CLK_DIV` cycles. `done` rises in the first cycle with `busy`=0.
- **Setup/hold at the chain.** Data changes only on the SHIFT_HI→SHIFT_LO transition, giving ≥ `CLK_DIV` cycles of setup and hold around the rising edge of `serial_clock`.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **Macro:** `MPRJ_IO_CFG_READBACK_EN`.
- **Defined:**
  - `cfg_re`=1 with `cfg_addr` < `NUM_PADS` → `cfg_rdata` = cfg[`cfg_addr`] on the next cycle; `cfg_rdata` holds that value until the next read.
  - An out-of-range read returns 0.
  - Reads are allowed while `busy`=1.
- **Undefined:** `cfg_re` is ignored and `cfg_rdata` is tied to 0. The store may be synthesised without a read mux.

## Test plan
- **Reset defaults.** Hold reset 3 cycles, release, then transfer with `NUM_PADS`=2, `CFG_BITS`=13, `CLK_DIV`=1 → the 26 bits captured on rising `serial_clock` equal {13'h0403, 13'h0403}. `busy` lasts 53 cycles and `done` pulses once.
- **Order check.** Write pad0=13'h1ABC and pad1=13'h0155, then start → the captured stream is 13'h0155 MSB-first followed by 13'h1ABC MSB-first. `serial_load` is high for exactly 1 cycle after the last falling edge.
- **Divider.** `CLK_DIV`=3 → every `serial_clock` half-period measures 3 cycles and `busy` lasts 2·3·26+3 = 159 cycles.
- **Ignored events.**
  - `cfg_we` to pad1 mid-transfer → the shifted data is unchanged and a later readback shows the old value.
  - `xfer_start` mid-transfer → no restart.
  - A write to `cfg_addr`=40 → no effect.
- **Reset mid-transfer.** Assert `wb_rst_i` at bit 7 → the next cycle shows `busy`=0, `serial_resetn`=0 and `serial_clock`=0; no `done` pulse; readback of every pad = 13'h0403.
- **Readback (macro defined).** Write pad1=13'h1FFF and assert `cfg_re` at pad1 → `cfg_rdata`=13'h1FFF one cycle later. With the macro undefined, `cfg_rdata` stays 0.
